spi_flash_slave: RTL and testbench

Synthesizable SPI flash target (mode 0, MSB first) that responds to the command set the team's flash controller issues: WREN, WRDI, RDSR, READ, PP, SE and BE. It oversamples SCK, CS_n and MOSI in the sys_clk domain, decodes opcode, address and data phases, and serves a small internal byte array.
It is used as an on-FPGA flash stand-in and as the loopback target for controller bring-up.

---
 rtl/spi_flash_pkg.sv | 27 ++
 rtl/spi_slave_sync_edge.sv | 42 ++++
 rtl/spi_flash_slave.sv | 233 +++++++++++++++++++++++
 tb/tb_spi_flash_slave.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash stand-in: opcodes,
// status bit positions and the slave FSM state encoding.
package spi_flash_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_SE   = 8'hD8;
    localparam logic [7:0] OP_BE   = 8'hC7;

    localparam int ST_WIP = 0;
    localparam int ST_WEL = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_ADDR,
        S_DIN,
        S_DOUT,
        S_CMD_END,
        S_IGNORE,
        S_ERASE
    } state_t;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Synchronises CS_n/SCK/MOSI into sys_clk and makes edge strobes.
// Ports: sys_clk, rst_n; i_cs_n, i_sck, i_mosi (async pins);
//        o_cs_n, o_mosi (synced); o_sck_rise/fall, o_cs_rise/fall.
module spi_slave_sync_edge (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic i_cs_n,
    input  logic i_sck,
    input  logic i_mosi,
    output logic o_cs_n,
    output logic o_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_cs_rise,
    output logic o_cs_fall
);

    // [1] is the synchronised level, [2] the previous one
    logic [2:0] r_cs;
    logic [2:0] r_sck;
    logic [1:0] r_mosi;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs   <= 3'b111;
            r_sck  <= 3'b000;
            r_mosi <= 2'b00;
        end else begin
            r_cs   <= {r_cs[1:0], i_cs_n};
            r_sck  <= {r_sck[1:0], i_sck};
            r_mosi <= {r_mosi[0], i_mosi};
        end
    end

    assign o_cs_n     = r_cs[1];
    assign o_mosi     = r_mosi[1];
    assign o_sck_rise = r_sck[1] & ~r_sck[2];
    assign o_sck_fall = ~r_sck[1] & r_sck[2];
    assign o_cs_rise  = r_cs[1] & ~r_cs[2];
    assign o_cs_fall  = ~r_cs[1] & r_cs[2];

endmodule

// File: rtl/spi_flash_slave.sv
// SPI flash target (mode 0) serving a small byte array.
// Ports: sys_clk, rst_n; spi_cs_n, spi_sck, spi_mosi in;
//        spi_miso out; wip, wel status outputs.
module spi_flash_slave
    import spi_flash_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int SECT_W = 4
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic spi_cs_n,
    input  logic spi_sck,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic wip,
    output logic wel
);

    localparam logic [ADDR_W-1:0] SECT_MASK =
        ADDR_W'((1 << SECT_W) - 1);

    logic w_cs_n, w_mosi, w_sck_rise, w_sck_fall;
    logic w_cs_rise, w_cs_fall;

    state_t r_state, w_nxt;

    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_rx;
    logic [7:0]        r_cmd, r_tx, r_rdata;
    logic [23:0]       r_addr;
    logic [1:0]        r_acnt;
    logic              r_wen, r_pp_any, r_ld, r_ld2;
    logic              r_wip, r_wel, r_miso, r_er_be;
    logic [ADDR_W-1:0] r_er_ptr;
    logic [7:0]        r_mem [0:(1<<ADDR_W)-1];

    logic [7:0]        w_byte, w_status, w_wdata;
    logic              w_bdone, w_commit, w_er_go;
    logic              w_er_last, w_pp_wr, w_we;
    logic [ADDR_W-1:0] w_waddr;

    spi_slave_sync_edge u_sync (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .i_cs_n     (spi_cs_n),
        .i_sck      (spi_sck),
        .i_mosi     (spi_mosi),
        .o_cs_n     (w_cs_n),
        .o_mosi     (w_mosi),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_cs_rise  (w_cs_rise),
        .o_cs_fall  (w_cs_fall)
    );

    always_comb begin
        w_status = '0;
        w_status[ST_WEL] = r_wel;
        w_status[ST_WIP] = r_wip;
    end

    assign w_byte   = {r_rx, w_mosi};
    assign w_bdone  = w_sck_rise & ~w_cs_n & (r_bit_cnt == 3'd7);
    // A frame only takes effect when CS_n rises on a byte boundary
    assign w_commit = w_cs_rise & (r_bit_cnt == 3'd0);
    assign w_er_go  = w_commit & r_wen & (r_state == S_CMD_END)
                    & ((r_cmd == OP_SE) | (r_cmd == OP_BE));
    assign w_pp_wr  = w_bdone & (r_state == S_DIN) & r_wen;
    assign w_er_last = r_er_be ? (&r_er_ptr)
                               : (&(r_er_ptr | ~SECT_MASK));

    // Program only clears bits; r_rdata already holds mem[addr]
    assign w_we    = r_wip | w_pp_wr;
    assign w_waddr = r_wip ? r_er_ptr : r_addr[ADDR_W-1:0];
    assign w_wdata = r_wip ? 8'hFF : (r_rdata & w_byte);

    always_ff @(posedge sys_clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
        r_rdata <= r_mem[r_addr[ADDR_W-1:0]];
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE:
                if (w_cs_fall) w_nxt = S_OPCODE;
            S_OPCODE:
                if (w_bdone) begin
                    if (r_wip && (w_byte != OP_RDSR))
                        w_nxt = S_IGNORE;
                    else begin
                        unique case (1'b1)
                            (w_byte == OP_WREN),
                            (w_byte == OP_WRDI),
                            (w_byte == OP_BE):   w_nxt = S_CMD_END;
                            (w_byte == OP_RDSR): w_nxt = S_DOUT;
                            (w_byte == OP_READ),
                            (w_byte == OP_PP),
                            (w_byte == OP_SE):   w_nxt = S_ADDR;
                            default:             w_nxt = S_IGNORE;
                        endcase
                    end
                end
            S_ADDR:
                if (w_bdone && (r_acnt == 2'd2)) begin
                    unique case (1'b1)
                        (r_cmd == OP_READ): w_nxt = S_DOUT;
                        (r_cmd == OP_PP):   w_nxt = S_DIN;
                        default:            w_nxt = S_CMD_END;
                    endcase
                end
            // Erase runs on its own; a new frame may poll status
            S_ERASE:
                if (w_cs_fall)
                    w_nxt = S_OPCODE;
                else if (!r_wip || w_er_last)
                    w_nxt = S_IDLE;
            default: ;
        endcase
        if ((r_state != S_ERASE) && w_cs_n)
            w_nxt = S_IDLE;
        if (w_er_go)
            w_nxt = S_ERASE;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_rx      <= '0;
            r_cmd     <= '0;
            r_tx      <= '0;
            r_addr    <= '0;
            r_acnt    <= '0;
            r_wen     <= 1'b0;
            r_pp_any  <= 1'b0;
            r_ld      <= 1'b0;
            r_ld2     <= 1'b0;
            r_miso    <= 1'b0;
            r_wip     <= 1'b0;
            r_wel     <= 1'b0;
            r_er_be   <= 1'b0;
            r_er_ptr  <= '0;
        end else begin
            // Two-stage READ fetch: addr settles, then RAM data
            r_ld2 <= r_ld;
            r_ld  <= 1'b0;
            if (w_cs_n) begin
                r_bit_cnt <= '0;
                r_tx      <= '0;
                r_miso    <= 1'b0;
                r_ld      <= 1'b0;
                r_ld2     <= 1'b0;
            end else begin
                if (w_sck_rise) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_rx      <= {r_rx[5:0], w_mosi};
                end
                if (w_sck_fall) begin
                    r_miso <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b0};
                end
                if (w_bdone) begin
                    case (r_state)
                        S_OPCODE: begin
                            r_cmd    <= w_byte;
                            r_wen    <= r_wel;
                            r_acnt   <= '0;
                            r_pp_any <= 1'b0;
                            if (w_nxt == S_DOUT)
                                r_tx <= w_status;
                        end
                        S_ADDR: begin
                            r_addr <= {r_addr[15:0], w_byte};
                            r_acnt <= r_acnt + 2'd1;
                            if (w_nxt == S_DOUT)
                                r_ld <= 1'b1;
                        end
                        S_DOUT:
                            if (r_cmd == OP_RDSR)
                                r_tx <= w_status;
                            else
                                r_ld <= 1'b1;
                        S_DIN: begin
                            r_pp_any    <= 1'b1;
                            r_addr[7:0] <= r_addr[7:0] + 8'd1;
                        end
                        default: ;
                    endcase
                end
                if (r_ld2) begin
                    r_tx   <= r_rdata;
                    r_addr <= r_addr + 24'd1;
                end
            end

            if (r_wip) begin
                r_er_ptr <= r_er_ptr + ADDR_W'(1);
                if (w_er_last) begin
                    r_wip <= 1'b0;
                    r_wel <= 1'b0;
                end
            end
            if (w_commit) begin
                if ((r_state == S_CMD_END) && (r_cmd == OP_WREN))
                    r_wel <= 1'b1;
                if ((r_state == S_CMD_END) && (r_cmd == OP_WRDI))
                    r_wel <= 1'b0;
                if ((r_state == S_DIN) && r_wen && r_pp_any)
                    r_wel <= 1'b0;
            end
            if (w_er_go) begin
                r_wip    <= 1'b1;
                r_er_be  <= (r_cmd == OP_BE);
                r_er_ptr <= (r_cmd == OP_BE) ? '0
                          : (r_addr[ADDR_W-1:0] & ~SECT_MASK);
            end
        end
    end

    assign spi_miso = r_miso;
    assign wip      = r_wip;
    assign wel      = r_wel;

endmodule

// File: tb/tb_spi_flash_slave.sv
// Bench for spi_flash_slave: SPI master tasks plus a
// byte-array reference model of the flash command set.
module tb_spi_flash_slave;

    localparam int HALF = 80;
    localparam int GAP  = 80;

    logic sys_clk = 1'b0;
    logic rst_n;
    logic spi_cs_n, spi_sck, spi_mosi;
    logic spi_miso, wip, wel;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] tq[$];
    logic [7:0] rq[$];
    logic [7:0] dq[$];
    logic [7:0] mm [256];
    bit         m_wel;

    always #5 sys_clk = ~sys_clk;

    spi_flash_slave #(.ADDR_W(8), .SECT_W(4)) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .wip      (wip),
        .wel      (wel)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input int nbits);
        logic [7:0] rb;
        rb = 8'h00;
        rq.delete();
        spi_cs_n = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tq[i/8][7-(i%8)];
            #(HALF);
            rb = {rb[6:0], spi_miso};
            spi_sck = 1'b1;
            #(HALF);
            spi_sck = 1'b0;
            if ((i % 8) == 7)
                rq.push_back(rb);
        end
        #(HALF);
        spi_cs_n = 1'b1;
        #(GAP);
    endtask

    task automatic hdr(input logic [7:0] op, input logic [23:0] a);
        tq.delete();
        tq.push_back(op);
        tq.push_back(a[23:16]);
        tq.push_back(a[15:8]);
        tq.push_back(a[7:0]);
    endtask

    task automatic do_op(input logic [7:0] op);
        tq.delete();
        tq.push_back(op);
        xfer(8);
        if (op == 8'h06) m_wel = 1'b1;
        if (op == 8'h04) m_wel = 1'b0;
    endtask

    task automatic do_read(input logic [23:0] a, input int n,
                           input string tag);
        logic [7:0] idx;
        hdr(8'h03, a);
        repeat (n) tq.push_back(8'h00);
        xfer(8 * (4 + n));
        for (int i = 0; i < n; i++) begin
            idx = a[7:0] + 8'(i);
            chk(tag, {24'h0, rq[4+i]}, {24'h0, mm[idx]});
        end
    endtask

    task automatic do_pp(input logic [23:0] a);
        logic [7:0] idx;
        hdr(8'h02, a);
        foreach (dq[i]) tq.push_back(dq[i]);
        xfer(8 * (4 + dq.size()));
        if (m_wel) begin
            foreach (dq[i]) begin
                idx = a[7:0] + 8'(i);
                mm[idx] = mm[idx] & dq[i];
            end
            if (dq.size() > 0) m_wel = 1'b0;
        end
    endtask

    task automatic do_rdsr(input string tag);
        tq.delete();
        tq.push_back(8'h05);
        tq.push_back(8'h00);
        xfer(16);
        chk(tag, {24'h0, rq[1]}, {30'h0, m_wel, 1'b0});
    endtask

    // Status must read busy (0x03) until it drops to 0x00 once
    task automatic poll(input bit want_busy);
        bit busy;
        tq.delete();
        tq.push_back(8'h05);
        repeat (6) tq.push_back(8'h00);
        xfer(56);
        if (want_busy)
            chk("poll_first", {24'h0, rq[1]}, 32'h03);
        busy = 1'b1;
        for (int i = 1; i < 7; i++) begin
            if (rq[i] == 8'h00) busy = 1'b0;
            chk("poll", {24'h0, rq[i]}, busy ? 32'h03 : 32'h00);
        end
        chk("poll_end", {24'h0, rq[6]}, 32'h00);
        m_wel = 1'b0;
    endtask

    task automatic do_be();
        tq.delete();
        tq.push_back(8'hC7);
        xfer(8);
        if (m_wel) begin
            for (int i = 0; i < 256; i++) mm[i] = 8'hFF;
            m_wel = 1'b0;
        end
    endtask

    task automatic do_se(input logic [23:0] a);
        logic [7:0] base;
        hdr(8'hD8, a);
        xfer(32);
        if (m_wel) begin
            base = a[7:0] & 8'hF0;
            for (int j = 0; j < 16; j++)
                mm[base + 8'(j)] = 8'hFF;
        end
        poll(1'b0);
    endtask

    task automatic abort_op(input logic [7:0] op, input int nb);
        tq.delete();
        tq.push_back(op);
        xfer(nb);
    endtask

    initial begin
        logic [23:0] a;
        int op;
        int n;
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        rst_n    = 1'b0;
        m_wel    = 1'b0;
        for (int i = 0; i < 256; i++) mm[i] = 8'hFF;
        repeat (4) @(posedge sys_clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_miso", {31'h0, spi_miso}, 32'h0);
        chk("rst_wip", {31'h0, wip}, 32'h0);
        chk("rst_wel", {31'h0, wel}, 32'h0);

        do_op(8'h06);
        chk("wel_port", {31'h0, wel}, {31'h0, m_wel});
        do_be();
        poll(1'b1);
        do_read(24'h000000, 4, "be_read");

        do_op(8'h06);
        dq = '{8'hA5, 8'h3C};
        do_pp(24'h000010);
        do_read(24'h000010, 2, "pp_read");
        do_rdsr("pp_rdsr");

        dq = '{8'h00};
        do_pp(24'h000020);
        do_read(24'h000020, 1, "nowel_read");
        do_rdsr("nowel_rdsr");

        do_op(8'h06);
        dq = '{8'h11, 8'h22, 8'h33};
        do_pp(24'h0000FE);
        do_read(24'h0000FE, 2, "wrap_read");
        do_read(24'h000000, 1, "wrap_read0");

        do_op(8'h06);
        dq = '{8'h5A};
        do_pp(24'h000020);
        do_op(8'h06);
        do_se(24'h000013);
        do_read(24'h00000F, 18, "se_read");

        abort_op(8'h06, 5);
        do_rdsr("abort_rdsr");
        chk("abort_wel", {31'h0, wel}, 32'h0);

        do_op(8'h06);
        do_be();
        hdr(8'h03, 24'h000000);
        repeat (2) tq.push_back(8'h00);
        xfer(48);
        foreach (rq[i])
            chk("busy_read", {24'h0, rq[i]}, 32'h0);
        poll(1'b0);
        do_read(24'h000000, 4, "be2_read");

        for (int k = 0; k < 30; k++) begin
            op = $urandom_range(0, 7);
            a  = 24'($urandom);
            case (op)
                0: do_op(8'h06);
                1: do_op(8'h04);
                2: begin
                    if ($urandom_range(0, 3) != 0) do_op(8'h06);
                    n = $urandom_range(1, 4);
                    dq.delete();
                    repeat (n) dq.push_back(8'($urandom));
                    do_pp(a);
                end
                3, 4: do_read(a, $urandom_range(1, 4), "rnd_read");
                5: do_rdsr("rnd_rdsr");
                6: begin
                    if ($urandom_range(0, 1) != 0) do_op(8'h06);
                    do_se(a);
                end
                default: begin
                    abort_op(($urandom_range(0, 1) != 0) ? 8'h06 : 8'h04,
                             $urandom_range(1, 7));
                    do_rdsr("rnd_abort");
                end
            endcase
            chk("rnd_wel", {31'h0, wel}, {31'h0, m_wel});
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
